// File: rtl/crf_pkg.sv
// Shared types and constants for the CRF tree pipeline controller.
// FSM encoding, geometry of the 8-stage tree, and counter helpers.
package crf_pkg;

   localparam int NUM_STAGES = 8;
   localparam int SAMPLE_W   = 256;
   localparam int THRES_W    = 32;

   // Counter widths for the programming sweep.
   localparam int STG_W = $clog2(NUM_STAGES);
   localparam int IDX_W = NUM_STAGES - 1;

   localparam logic STATE_LOAD = 1'b1;
   localparam logic STATE_RUN  = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DRAIN
   } fsm_e;

   // Highest node index of a stage: 2^s - 1 for zero-based stage s.
   function automatic logic [IDX_W-1:0] last_index(
      input logic [STG_W-1:0] s
   );
      logic [IDX_W-1:0] r;
      for (int b = 0; b < IDX_W; b++) begin
         r[b] = (b < int'(s));
      end
      return r;
   endfunction

   function automatic logic [NUM_STAGES-1:0] stage_onehot(
      input logic [STG_W-1:0] s
   );
      logic [NUM_STAGES-1:0] r;
      r    = '0;
      r[s] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/crf_valid_delay.sv
// DEPTH-cycle shift register carrying a valid bit, async active-low clear.
// Ports: clk, rst_n, in_i (valid in), out_o (valid DEPTH cycles later).
module crf_valid_delay #(
   parameter int DEPTH = 38
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_i,
   output logic out_o
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   generate
      if (DEPTH == 1) begin : g_one
         always_comb sr_d = in_i;
      end else begin : g_many
         always_comb sr_d = {sr_q[DEPTH-2:0], in_i};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign out_o = sr_q[DEPTH-1];

endmodule

// File: rtl/crf_pipe_controller.sv
// Load/run sequencer for the 8-stage CRF tree pipeline.
// Ports: load_req/run_req mode requests; cfg_* config word stream
// (valid/ready, last); smp_* sample stream (valid/ready); state
// (1=load, 0=run); thresData/thresNodeIndex/stage_we memory write
// broadcast; sampleData_o/issue_valid into stage 1; nodeIndexOut root
// index; decision_valid leaf strobe; busy; cfg_err sticky error.
// Optional: define CRF_CTRL_PERF_EN for perf_samples/perf_drain_cycles.
module crf_pipe_controller
   import crf_pkg::*;
#(
   parameter int PIPE_LATENCY = 38
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_req,
   input  logic                  run_req,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [THRES_W-1:0]    cfg_data,
   input  logic                  cfg_last,
   input  logic                  smp_valid,
   output logic                  smp_ready,
   input  logic [SAMPLE_W-1:0]   smp_data,
   output logic                  state,
   output logic [THRES_W-1:0]    thresData,
   output logic [NUM_STAGES-1:0] thresNodeIndex,
   output logic [NUM_STAGES-1:0] stage_we,
   output logic [SAMPLE_W-1:0]   sampleData_o,
   output logic                  nodeIndexOut,
   output logic                  issue_valid,
   output logic                  decision_valid,
   output logic                  busy,
   output logic                  cfg_err
`ifdef CRF_CTRL_PERF_EN
   ,
   output logic [31:0]           perf_samples,
   output logic [31:0]           perf_drain_cycles
`endif
);

   localparam int CNT_W = $clog2(PIPE_LATENCY + 2);
   localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);

   fsm_e                  fsm_q, fsm_d;
   logic                  loaded_q, loaded_d;
   logic                  err_q, err_d;
   logic [STG_W-1:0]      stg_q, stg_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [THRES_W-1:0]    wdata_q, wdata_d;
   logic [NUM_STAGES-1:0] widx_q, widx_d;
   logic [NUM_STAGES-1:0] we_q, we_d;
   logic [SAMPLE_W-1:0]   smp_q, smp_d;
   logic                  iss_q, iss_d;
   logic [CNT_W-1:0]      infl_q, infl_d;
   logic                  dec_v;
   logic                  last_word;

   crf_valid_delay #(
      .DEPTH (PIPE_LATENCY)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (iss_q),
      .out_o (dec_v)
   );

   always_comb begin
      fsm_d     = fsm_q;
      loaded_d  = loaded_q;
      err_d     = err_q;
      stg_d     = stg_q;
      idx_d     = idx_q;
      wdata_d   = '0;
      widx_d    = '0;
      we_d      = '0;
      smp_d     = '0;
      iss_d     = 1'b0;
      cfg_ready = 1'b0;
      smp_ready = 1'b0;
      last_word = (stg_q == STG_LAST) &&
                  (idx_q == last_index(stg_q));

      // Issue and retire in one cycle cancel out.
      unique case ({iss_q, dec_v})
         2'b10:   infl_d = infl_q + CNT_W'(1);
         2'b01:   infl_d = infl_q - CNT_W'(1);
         default: infl_d = infl_q;
      endcase

      unique case (fsm_q)
         IDLE: begin
            if (load_req) begin
               fsm_d    = LOAD;
               stg_d    = '0;
               idx_d    = '0;
               err_d    = 1'b0;
               loaded_d = 1'b0;
            end else if (run_req && loaded_q) begin
               fsm_d = RUN;
            end
         end
         LOAD: begin
            // A restart request takes the cycle; no word is taken.
            cfg_ready = !load_req;
            if (load_req) begin
               stg_d    = '0;
               idx_d    = '0;
               err_d    = 1'b0;
               loaded_d = 1'b0;
            end else if (cfg_valid) begin
               we_d    = stage_onehot(stg_q);
               widx_d  = {1'b0, idx_q};
               wdata_d = cfg_data;
               if (last_word || cfg_last) begin
                  fsm_d    = IDLE;
                  loaded_d = last_word && cfg_last;
                  err_d    = !(last_word && cfg_last);
               end else if (idx_q == last_index(stg_q)) begin
                  stg_d = stg_q + STG_W'(1);
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         RUN: begin
            smp_ready = 1'b1;
            if (smp_valid) begin
               smp_d = smp_data;
               iss_d = 1'b1;
            end
            if (load_req) begin
               fsm_d = DRAIN;
            end
         end
         DRAIN: begin
            // Look at the post-update count so LOAD starts the cycle
            // right after the last decision retires.
            if (infl_d == '0) begin
               fsm_d    = LOAD;
               stg_d    = '0;
               idx_d    = '0;
               err_d    = 1'b0;
               loaded_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= IDLE;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         stg_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         widx_q   <= '0;
         we_q     <= '0;
         smp_q    <= '0;
         iss_q    <= 1'b0;
         infl_q   <= '0;
      end else begin
         fsm_q    <= fsm_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         stg_q    <= stg_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         widx_q   <= widx_d;
         we_q     <= we_d;
         smp_q    <= smp_d;
         iss_q    <= iss_d;
         infl_q   <= infl_d;
      end
   end

   assign state          = (fsm_q == RUN || fsm_q == DRAIN) ?
                           STATE_RUN : STATE_LOAD;
   assign busy           = (fsm_q != IDLE);
   assign cfg_err        = err_q;
   assign thresData      = wdata_q;
   assign thresNodeIndex = widx_q;
   assign stage_we       = we_q;
   assign sampleData_o   = smp_q;
   assign issue_valid    = iss_q;
   assign decision_valid = dec_v;
   assign nodeIndexOut   = 1'b0;

`ifdef CRF_CTRL_PERF_EN
   logic [31:0] perf_smp_q, perf_smp_d;
   logic [31:0] perf_drn_q, perf_drn_d;

   always_comb begin
      perf_smp_d = perf_smp_q;
      perf_drn_d = perf_drn_q;
      if (iss_q && perf_smp_q != '1) begin
         perf_smp_d = perf_smp_q + 32'd1;
      end
      if (fsm_q == DRAIN && perf_drn_q != '1) begin
         perf_drn_d = perf_drn_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_smp_q <= '0;
         perf_drn_q <= '0;
      end else begin
         perf_smp_q <= perf_smp_d;
         perf_drn_q <= perf_drn_d;
      end
   end

   assign perf_samples      = perf_smp_q;
   assign perf_drain_cycles = perf_drn_q;
`endif

endmodule

// File: tb/tb_crf_pipe_controller.sv
// Directed scoreboard bench for crf_pipe_controller.
// Covers load sweep, load error, run timing, drain, reset flush, perf.
module tb_crf_pipe_controller;
   import crf_pkg::*;

   localparam int LAT = 38;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_req = 1'b0;
   logic run_req = 1'b0;
   logic cfg_valid = 1'b0;
   logic cfg_last = 1'b0;
   logic smp_valid = 1'b0;
   logic [THRES_W-1:0] cfg_data = '0;
   logic [SAMPLE_W-1:0] smp_data = '0;

   logic cfg_ready, smp_ready, state, nodeIndexOut;
   logic issue_valid, decision_valid, busy, cfg_err;
   logic [THRES_W-1:0] thresData;
   logic [NUM_STAGES-1:0] thresNodeIndex, stage_we;
   logic [SAMPLE_W-1:0] sampleData_o;
`ifdef CRF_CTRL_PERF_EN
   logic [31:0] perf_samples, perf_drain_cycles;
`endif

   crf_pipe_controller #(
      .PIPE_LATENCY (LAT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_req       (load_req),
      .run_req        (run_req),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_data       (cfg_data),
      .cfg_last       (cfg_last),
      .smp_valid      (smp_valid),
      .smp_ready      (smp_ready),
      .smp_data       (smp_data),
      .state          (state),
      .thresData      (thresData),
      .thresNodeIndex (thresNodeIndex),
      .stage_we       (stage_we),
      .sampleData_o   (sampleData_o),
      .nodeIndexOut   (nodeIndexOut),
      .issue_valid    (issue_valid),
      .decision_valid (decision_valid),
      .busy           (busy),
      .cfg_err        (cfg_err)
`ifdef CRF_CTRL_PERF_EN
      ,
      .perf_samples      (perf_samples),
      .perf_drain_cycles (perf_drain_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  we;
      logic [7:0]  idx;
      logic [31:0] data;
   } cfg_exp_t;

   cfg_exp_t cfg_q[$];
   int iss_cyc_q[$];
   logic [SAMPLE_W-1:0] iss_dat_q[$];
   int dec_q[$];

   int cyc = 0;
   int n_vec = 0;
   int n_mis = 0;
   int last_dec = 0;

   task automatic check(input string tag,
                        input logic [255:0] obs,
                        input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops scoreboard entries whenever the DUT strobes an output.
   task automatic monitor();
      cfg_exp_t e;
      if (stage_we !== '0) begin
         if (cfg_q.size() == 0) begin
            check("we_unexpected", stage_we, 0);
         end else begin
            e = cfg_q.pop_front();
            check("stage_we", stage_we, e.we);
            check("node_index", thresNodeIndex, e.idx);
            check("thres_data", thresData, e.data);
         end
      end
      if (issue_valid !== 1'b0) begin
         if (iss_cyc_q.size() == 0) begin
            check("issue_unexpected", issue_valid, 0);
         end else begin
            check("issue_cycle", cyc, iss_cyc_q.pop_front());
            check("issue_data", sampleData_o, iss_dat_q.pop_front());
         end
      end
      if (decision_valid !== 1'b0) begin
         if (dec_q.size() == 0) begin
            check("decision_unexpected", decision_valid, 0);
         end else begin
            check("decision_cycle", cyc, dec_q.pop_front());
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic load(input int n, input int last_at);
      cfg_exp_t e;
      int m, s;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      for (int k = 0; k < n; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = 32'(k + 1);
         cfg_last  = (k + 1 == last_at);
         #1;
         check("cfg_ready", cfg_ready, 1);
         m = k + 1;
         s = 0;
         for (int b = 0; b < 8; b++) if (m[b]) s = b;
         e.we   = 8'(1 << s);
         e.idx  = 8'(m - (1 << s));
         e.data = 32'(k + 1);
         cfg_q.push_back(e);
         tick();
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      tick();
      check("cfg_q_drained", cfg_q.size(), 0);
   endtask

   task automatic samples(input int n);
      logic [SAMPLE_W-1:0] d;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < SAMPLE_W / 32; j++) d[j*32 +: 32] = $urandom();
         smp_valid = 1'b1;
         smp_data  = d;
         #1;
         check("smp_ready", smp_ready, 1);
         iss_cyc_q.push_back(cyc + 1);
         iss_dat_q.push_back(d);
         last_dec = cyc + 1 + LAT;
         dec_q.push_back(last_dec);
         tick();
      end
      smp_valid = 1'b0;
      smp_data  = '0;
   endtask

   task automatic drain(output int dcyc);
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      #1;
      dcyc = 0;
      check("drain_smp_ready", smp_ready, 0);
      check("drain_busy", busy, 1);
      for (int i = 0; i < 300 && state !== STATE_LOAD; i++) begin
         if (busy && !state && !smp_ready) dcyc++;
         tick();
      end
      check("drain_exit_state", state, STATE_LOAD);
      check("drain_exit_cycle", cyc, last_dec + 1);
      check("drain_dec_left", dec_q.size(), 0);
   endtask

   task automatic reset_outputs(input string tag);
      check({tag, "_state"}, state, STATE_LOAD);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_we"}, stage_we, 0);
      check({tag, "_tdata"}, thresData, 0);
      check({tag, "_tidx"}, thresNodeIndex, 0);
      check({tag, "_sdata"}, sampleData_o, 0);
      check({tag, "_issue"}, issue_valid, 0);
      check({tag, "_dec"}, decision_valid, 0);
      check({tag, "_cfg_ready"}, cfg_ready, 0);
      check({tag, "_smp_ready"}, smp_ready, 0);
      check({tag, "_cfg_err"}, cfg_err, 0);
      check({tag, "_root"}, nodeIndexOut, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int dcyc;
      repeat (3) @(negedge clk);
      reset_outputs("reset");
      rst_n = 1'b1;

      // run_req before any load is ignored
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      check("run_unloaded_busy", busy, 0);

      // full programming sweep
      load(255, 255);
      check("load_ok_busy", busy, 0);
      check("load_ok_err", cfg_err, 0);

      // premature cfg_last on word 10
      load(10, 10);
      check("load_err_flag", cfg_err, 1);
      check("load_err_busy", busy, 0);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      check("run_after_err_busy", busy, 0);
      check("run_after_err_state", state, STATE_LOAD);

      // load and run requested together: load wins
      load(255, 255);
      load_req = 1'b1;
      run_req  = 1'b1;
      tick();
      load_req = 1'b0;
      run_req  = 1'b0;
      #1;
      check("both_req_state", state, STATE_LOAD);
      check("both_req_cfg_ready", cfg_ready, 1);
      load(255, 255);

      // five back-to-back samples, then drain into reload
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      check("run_state", state, STATE_RUN);
      check("run_busy", busy, 1);
      samples(5);
      tick();
      tick();
      check("run_hold_state", state, STATE_RUN);
      drain(dcyc);
      check("after_drain_cfg_ready", cfg_ready, 1);

      // reset with ten samples in flight
      load(255, 255);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      samples(10);
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      reset_outputs("midrst");
      iss_cyc_q.delete();
      iss_dat_q.delete();
      dec_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 10) tick();
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      check("run_after_rst_busy", busy, 0);

`ifdef CRF_CTRL_PERF_EN
      check("perf_smp_reset", perf_samples, 0);
      check("perf_drn_reset", perf_drain_cycles, 0);
      load(255, 255);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      samples(100);
      drain(dcyc);
      check("perf_samples", perf_samples, 100);
      check("perf_drain_cycles", perf_drain_cycles, dcyc);
`endif

      check("iss_left", iss_cyc_q.size(), 0);
      check("dec_left", dec_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
